// File: rtl/ysyx_25030093_sram_responder_if.sv
// Request/response handshake between an IFU/LSU requester and the SRAM responder.
// The requester uses the master modport and the responder uses the slave modport.
interface ysyx_25030093_sram_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_wmask, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_wmask, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/ysyx_25030093_sram_responder.sv
// Word-array SRAM responder: takes one request at a time, holds it for LATENCY cycles,
// then presents read data or a write acknowledge until the requester takes it.
module ysyx_25030093_sram_responder #(
    parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned LATENCY   = 2
) (
    input logic clk,
    input logic rst,
    ysyx_25030093_sram_responder_if.slave bus
);

    localparam int unsigned IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [32:0] SPAN     = 33'(DEPTH) << 2;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);
    localparam bit          DIRECT   = (LATENCY == 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_e;

    state_e            state_q;
    logic [3:0]        cnt_q;
    logic [3:0]        cnt_d;
    logic              reqReady_q;
    logic              rspValid_q;
    logic [31:0]       rspRdata_q;
    logic              rspErr_q;

    logic              wen_q;
    logic [IDX_W-1:0]  idx_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wmask_q;
    logic              inRange_q;

    logic [31:0]       mem [DEPTH];

    logic [32:0]       reqOffset;
    logic              reqInRange;
    logic [IDX_W-1:0]  reqIdx;
    logic              accept;
    logic              complete;

    logic              accWen;
    logic [IDX_W-1:0]  accIdx;
    logic [31:0]       accWdata;
    logic [3:0]        accWmask;
    logic              accInRange;
    logic [31:0]       accRdata;
    logic              accErr;

    // A 33-bit difference keeps addresses below ADDR_BASE from wrapping into range.
    assign reqOffset  = {1'b0, bus.req_addr} - {1'b0, ADDR_BASE};
    assign reqInRange = !reqOffset[32] && (reqOffset < SPAN);
    assign reqIdx     = reqOffset[IDX_W+1:2];

    assign accept = (state_q == IDLE) && bus.req_valid;
    assign cnt_d  = cnt_q - 4'd1;

    // With a one-cycle latency the access completes on the acceptance edge itself,
    // so it must use the live request fields instead of the latched copies.
    always_comb begin
        accWen     = wen_q;
        accIdx     = idx_q;
        accWdata   = wdata_q;
        accWmask   = wmask_q;
        accInRange = inRange_q;
        if (DIRECT) begin
            accWen     = bus.req_wen;
            accIdx     = reqIdx;
            accWdata   = bus.req_wdata;
            accWmask   = bus.req_wmask;
            accInRange = reqInRange;
        end
    end

    assign complete = !rst && (DIRECT ? accept : ((state_q == BUSY) && (cnt_d == 4'd0)));
    assign accErr   = !accInRange;
    assign accRdata = (!accWen && accInRange) ? mem[accIdx] : 32'h0;

    // The array has no reset; a write is committed only on the edge that enters RESP.
    always_ff @(posedge clk) begin
        if (complete && accWen && accInRange) begin
            for (int i = 0; i < 4; i++) begin
                if (accWmask[i]) begin
                    mem[accIdx][8*i +: 8] <= accWdata[8*i +: 8];
                end
            end
        end
    end

    // cnt_q holds the BUSY cycles still to run; leaving BUSY when it would reach zero
    // places rsp_valid exactly LATENCY cycles after acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            reqReady_q <= 1'b1;
            rspValid_q <= 1'b0;
            rspRdata_q <= 32'h0;
            rspErr_q   <= 1'b0;
            wen_q      <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= 32'h0;
            wmask_q    <= 4'h0;
            inRange_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        wen_q      <= bus.req_wen;
                        idx_q      <= reqIdx;
                        wdata_q    <= bus.req_wdata;
                        wmask_q    <= bus.req_wmask;
                        inRange_q  <= reqInRange;
                        reqReady_q <= 1'b0;
                        if (DIRECT) begin
                            state_q    <= RESP;
                            rspValid_q <= 1'b1;
                            rspRdata_q <= accRdata;
                            rspErr_q   <= accErr;
                        end else begin
                            state_q <= BUSY;
                            cnt_q   <= CNT_INIT;
                        end
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_d;
                    if (cnt_d == 4'd0) begin
                        state_q    <= RESP;
                        rspValid_q <= 1'b1;
                        rspRdata_q <= accRdata;
                        rspErr_q   <= accErr;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state_q    <= IDLE;
                        rspValid_q <= 1'b0;
                        rspRdata_q <= 32'h0;
                        rspErr_q   <= 1'b0;
                        reqReady_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = reqReady_q;
    assign bus.rsp_valid = rspValid_q;
    assign bus.rsp_rdata = rspRdata_q;
    assign bus.rsp_err   = rspErr_q;

endmodule
